// File: rtl/mh_bridge_pkg.sv
// Shared types and sizing helpers for the multi-head ping-pong bridge.
package mh_bridge_pkg;

  localparam int unsigned DEF_NUM_HEADS = 2;
  localparam int unsigned DEF_W_WIDTH   = 16;
  localparam int unsigned DEF_N_WIDTH   = 16;
  localparam int unsigned DEF_DEPTH     = 4;
  localparam int unsigned DEF_REPLAY    = 1;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_CLR,
    ST_RUN,
    ST_WAIT,
    ST_REL
  } state_e;

  // Word-index width; a depth of 1 would still need one address bit.
  function automatic int unsigned addr_w(input int unsigned depth);
    return (depth > 1) ? $clog2(depth) : 1;
  endfunction

  function automatic int unsigned pass_w(input int unsigned replay);
    return $clog2(replay) + 1;
  endfunction

  localparam int unsigned DEF_ADDR_W = addr_w(DEF_DEPTH);
  localparam int unsigned DEF_PASS_W = pass_w(DEF_REPLAY);

endpackage

// File: rtl/mh_pingpong_bridge_bank_ram.sv
// Two-bank x DEPTH simple dual-port array with a registered read port.
module bridge_bank_ram #(
  parameter int unsigned DW    = 32,
  parameter int unsigned DEPTH = 4,
  parameter int unsigned AW    = 2
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          wr_en_i,
  input  logic          wr_bank_i,
  input  logic [AW-1:0] wr_addr_i,
  input  logic [DW-1:0] wr_data_i,
  input  logic          rd_en_i,
  input  logic          rd_bank_i,
  input  logic [AW-1:0] rd_addr_i,
  output logic [DW-1:0] rd_data_o
);

  logic [DW-1:0] mem_q [2][DEPTH];
  logic [DW-1:0] rd_data_q;

  always_ff @(posedge clk) begin
    if (wr_en_i) mem_q[wr_bank_i][wr_addr_i] <= wr_data_i;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst)          rd_data_q <= '0;
    else if (rd_en_i) rd_data_q <= mem_q[rd_bank_i][rd_addr_i];
  end

  assign rd_data_o = rd_data_q;

endmodule

// File: rtl/mh_pingpong_bridge.sv
// Ping-pong bridge buffering Q/K head streams into two banks and replaying them to the matmul.
// Optional sticky overflow detection is enabled by defining BRIDGE_OVERFLOW_CHECK_EN.
module mh_pingpong_bridge
  import mh_bridge_pkg::*;
#(
  parameter int unsigned NUM_HEADS = DEF_NUM_HEADS,
  parameter int unsigned W_WIDTH   = DEF_W_WIDTH,
  parameter int unsigned N_WIDTH   = DEF_N_WIDTH,
  parameter int unsigned DEPTH     = DEF_DEPTH,
  parameter int unsigned REPLAY    = DEF_REPLAY
) (
  input  logic                         clk,
  input  logic                         rst,
  input  logic                         in_valid,
  output logic                         in_ready,
  input  logic [NUM_HEADS*W_WIDTH-1:0] in_w_data,
  input  logic [NUM_HEADS*N_WIDTH-1:0] in_n_data,
  output logic [NUM_HEADS*W_WIDTH-1:0] w_dout,
  output logic [NUM_HEADS*N_WIDTH-1:0] n_dout,
  output logic                         mm_rst_n,
  output logic                         mm_reset_acc,
  output logic                         mm_en,
  input  logic                         acc_done,
  output logic [1:0]                   bank_full,
  output logic                         pass_done,
  output logic                         ovf_err
);

  localparam int unsigned AW  = addr_w(DEPTH);
  localparam int unsigned PW  = pass_w(REPLAY);
  localparam int unsigned WDW = NUM_HEADS * W_WIDTH;
  localparam int unsigned NDW = NUM_HEADS * N_WIDTH;

  state_e          state_q, state_d;
  logic            wr_bank_q, wr_bank_d, rd_bank_q, rd_bank_d;
  logic [AW-1:0]   wr_cnt_q, wr_cnt_d, rd_cnt_q, rd_cnt_d;
  logic [PW-1:0]   pass_cnt_q, pass_cnt_d;
  logic [1:0]      bank_full_q, bank_full_d, bank_set, bank_clr;
  logic            first_clr_q, first_clr_d;
  logic            mm_en_q, mm_en_d, mm_reset_acc_q, mm_reset_acc_d;
  logic            mm_rst_n_q, mm_rst_n_d, pass_done_q, pass_done_d;
  logic            wr_fire, rd_en;

  assign in_ready = ~bank_full_q[wr_bank_q];
  assign wr_fire  = in_valid & in_ready;

  // Write side: fill the current write bank, hand it over when the last word lands.
  always_comb begin
    wr_cnt_d  = wr_cnt_q;
    wr_bank_d = wr_bank_q;
    bank_set  = '0;
    if (wr_fire) begin
      if (wr_cnt_q == AW'(DEPTH - 1)) begin
        bank_set[wr_bank_q] = 1'b1;
        wr_bank_d           = ~wr_bank_q;
        wr_cnt_d            = '0;
      end else begin
        wr_cnt_d = wr_cnt_q + AW'(1);
      end
    end
  end

  // Read FSM; outputs are registered from the next state so they align with it.
  always_comb begin
    state_d     = state_q;
    rd_cnt_d    = rd_cnt_q;
    rd_bank_d   = rd_bank_q;
    pass_cnt_d  = pass_cnt_q;
    bank_clr    = '0;
    first_clr_d = first_clr_q;
    case (state_q)
      ST_IDLE: if (bank_full_q[rd_bank_q]) state_d = ST_CLR;
      ST_CLR: begin
        rd_cnt_d    = '0;
        first_clr_d = 1'b0;
        state_d     = ST_RUN;
      end
      ST_RUN: begin
        if (rd_cnt_q == AW'(DEPTH - 1)) state_d = ST_WAIT;
        else                            rd_cnt_d = rd_cnt_q + AW'(1);
      end
      ST_WAIT: begin
        if (acc_done) begin
          if (pass_cnt_q != PW'(REPLAY - 1)) begin
            pass_cnt_d = pass_cnt_q + PW'(1);
            state_d    = ST_CLR;
          end else begin
            state_d = ST_REL;
          end
        end
      end
      ST_REL: begin
        bank_clr[rd_bank_q] = 1'b1;
        rd_bank_d           = ~rd_bank_q;
        pass_cnt_d          = '0;
        state_d             = ST_IDLE;
      end
      default: state_d = ST_IDLE;
    endcase
    bank_full_d    = (bank_full_q | bank_set) & ~bank_clr;
    mm_en_d        = (state_d == ST_RUN);
    mm_reset_acc_d = (state_d == ST_CLR);
    mm_rst_n_d     = ~((state_d == ST_CLR) & first_clr_q);
    pass_done_d    = (state_d == ST_REL);
  end

  // Read address leads by one cycle so RAM data lines up with mm_en.
  assign rd_en = (state_d == ST_RUN);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q        <= ST_IDLE;
      wr_bank_q      <= 1'b0;
      rd_bank_q      <= 1'b0;
      wr_cnt_q       <= '0;
      rd_cnt_q       <= '0;
      pass_cnt_q     <= '0;
      bank_full_q    <= '0;
      first_clr_q    <= 1'b1;
      mm_en_q        <= 1'b0;
      mm_reset_acc_q <= 1'b0;
      mm_rst_n_q     <= 1'b0;
      pass_done_q    <= 1'b0;
    end else begin
      state_q        <= state_d;
      wr_bank_q      <= wr_bank_d;
      rd_bank_q      <= rd_bank_d;
      wr_cnt_q       <= wr_cnt_d;
      rd_cnt_q       <= rd_cnt_d;
      pass_cnt_q     <= pass_cnt_d;
      bank_full_q    <= bank_full_d;
      first_clr_q    <= first_clr_d;
      mm_en_q        <= mm_en_d;
      mm_reset_acc_q <= mm_reset_acc_d;
      mm_rst_n_q     <= mm_rst_n_d;
      pass_done_q    <= pass_done_d;
    end
  end

  bridge_bank_ram #(.DW(WDW), .DEPTH(DEPTH), .AW(AW)) u_west_ram (
    .clk       (clk),
    .rst       (rst),
    .wr_en_i   (wr_fire),
    .wr_bank_i (wr_bank_q),
    .wr_addr_i (wr_cnt_q),
    .wr_data_i (in_w_data),
    .rd_en_i   (rd_en),
    .rd_bank_i (rd_bank_q),
    .rd_addr_i (rd_cnt_d),
    .rd_data_o (w_dout)
  );

  bridge_bank_ram #(.DW(NDW), .DEPTH(DEPTH), .AW(AW)) u_north_ram (
    .clk       (clk),
    .rst       (rst),
    .wr_en_i   (wr_fire),
    .wr_bank_i (wr_bank_q),
    .wr_addr_i (wr_cnt_q),
    .wr_data_i (in_n_data),
    .rd_en_i   (rd_en),
    .rd_bank_i (rd_bank_q),
    .rd_addr_i (rd_cnt_d),
    .rd_data_o (n_dout)
  );

  assign mm_en        = mm_en_q;
  assign mm_reset_acc = mm_reset_acc_q;
  assign mm_rst_n     = mm_rst_n_q;
  assign pass_done    = pass_done_q;
  assign bank_full    = bank_full_q;

`ifdef BRIDGE_OVERFLOW_CHECK_EN
  logic ovf_q;
  always_ff @(posedge clk or posedge rst) begin
    if (rst)                       ovf_q <= 1'b0;
    else if (in_valid & ~in_ready) ovf_q <= 1'b1;
  end
  assign ovf_err = ovf_q;
`else
  assign ovf_err = 1'b0;
`endif

endmodule

// File: tb/tb_mh_pingpong_bridge.sv
// Scoreboard bench for mh_pingpong_bridge: default instance plus a REPLAY=2 instance.
module tb_mh_pingpong_bridge;

`ifdef BRIDGE_OVERFLOW_CHECK_EN
  localparam logic EXP_OVF = 1'b1;
`else
  localparam logic EXP_OVF = 1'b0;
`endif

  typedef struct packed {
    logic [31:0] w;
    logic [31:0] n;
  } beat_t;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  logic        in_valid, in_ready, mm_rst_n, mm_reset_acc, mm_en, acc_done, pass_done, ovf_err;
  logic [31:0] in_w_data, in_n_data, w_dout, n_dout;
  logic [1:0]  bank_full;

  logic        r2_in_valid, r2_in_ready, r2_mm_rst_n, r2_mm_reset_acc, r2_mm_en;
  logic        r2_acc_done, r2_pass_done, r2_ovf_err;
  logic [31:0] r2_in_w_data, r2_in_n_data, r2_w_dout, r2_n_dout;
  logic [1:0]  r2_bank_full;

  mh_pingpong_bridge u_dut (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready),
    .in_w_data(in_w_data), .in_n_data(in_n_data), .w_dout(w_dout), .n_dout(n_dout),
    .mm_rst_n(mm_rst_n), .mm_reset_acc(mm_reset_acc), .mm_en(mm_en), .acc_done(acc_done),
    .bank_full(bank_full), .pass_done(pass_done), .ovf_err(ovf_err)
  );

  mh_pingpong_bridge #(.REPLAY(2)) u_dut_r2 (
    .clk(clk), .rst(rst), .in_valid(r2_in_valid), .in_ready(r2_in_ready),
    .in_w_data(r2_in_w_data), .in_n_data(r2_in_n_data), .w_dout(r2_w_dout), .n_dout(r2_n_dout),
    .mm_rst_n(r2_mm_rst_n), .mm_reset_acc(r2_mm_reset_acc), .mm_en(r2_mm_en),
    .acc_done(r2_acc_done), .bank_full(r2_bank_full), .pass_done(r2_pass_done),
    .ovf_err(r2_ovf_err)
  );

  beat_t      q1[$], q2[$];
  logic [1:0] pq1[$], pq2[$];
  int         n_cmp = 0;
  int         n_bad = 0;
  beat_t      be1, be2;
  logic [1:0] pe1, pe2;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  // Monitor: every mm_en beat and pass_done pulse is matched against the scoreboard.
  always @(negedge clk) begin
    if (!rst) begin
      if (mm_en) begin
        if (q1.size() == 0) begin
          n_cmp++; n_bad++;
          $display("FAIL beat1: unexpected beat w=0x%0h", w_dout);
        end else begin
          be1 = q1.pop_front();
          check("beat1_w", 64'(w_dout), 64'(be1.w));
          check("beat1_n", 64'(n_dout), 64'(be1.n));
        end
      end
      if (pass_done) begin
        if (pq1.size() == 0) begin
          n_cmp++; n_bad++;
          $display("FAIL pass1: unexpected pass_done");
        end else begin
          pe1 = pq1.pop_front();
          check("pass1_bank_full", 64'(bank_full), 64'(pe1));
        end
      end
      if (r2_mm_en) begin
        if (q2.size() == 0) begin
          n_cmp++; n_bad++;
          $display("FAIL beat2: unexpected beat w=0x%0h", r2_w_dout);
        end else begin
          be2 = q2.pop_front();
          check("beat2_w", 64'(r2_w_dout), 64'(be2.w));
          check("beat2_n", 64'(r2_n_dout), 64'(be2.n));
        end
      end
      if (r2_pass_done) begin
        if (pq2.size() == 0) begin
          n_cmp++; n_bad++;
          $display("FAIL pass2: unexpected pass_done");
        end else begin
          pe2 = pq2.pop_front();
          check("pass2_bank_full", 64'(r2_bank_full), 64'(pe2));
        end
      end
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic wr(input bit d2, input int b, input int k, input bit push);
    logic [31:0] wd, nd;
    wd = {16'(b + k + 1), 16'(b + k)};
    nd = {16'(32'hB000 + b + k), 16'(32'hA000 + b + k)};
    if (d2) begin
      r2_in_valid = 1'b1; r2_in_w_data = wd; r2_in_n_data = nd;
    end else begin
      in_valid = 1'b1; in_w_data = wd; in_n_data = nd;
    end
    tick();
    in_valid    = 1'b0;
    r2_in_valid = 1'b0;
    if (push) begin
      if (d2) q2.push_back('{w: wd, n: nd});
      else    q1.push_back('{w: wd, n: nd});
    end
  endtask

  task automatic wait_en(input bit d2, input logic lvl, input string name);
    bit ok;
    ok = 1'b0;
    for (int i = 0; i < 40 && !ok; i++) begin
      if ((d2 ? r2_mm_en : mm_en) == lvl) ok = 1'b1;
      else tick();
    end
    if (!ok) begin
      n_cmp++; n_bad++;
      $display("FAIL %s: mm_en never reached %0b", name, lvl);
    end
  endtask

  task automatic acc(input bit d2);
    if (d2) r2_acc_done = 1'b1;
    else    acc_done    = 1'b1;
    tick();
    acc_done    = 1'b0;
    r2_acc_done = 1'b0;
  endtask

  task automatic do_reset();
    rst = 1'b1;
    #1;
    check("rst_in_ready", 64'(in_ready), 64'(1));
    check("rst_mm_en", 64'(mm_en), 64'(0));
    check("rst_bank_full", 64'(bank_full), 64'(0));
    check("rst_w_dout", 64'(w_dout), 64'(0));
    tick();
    rst = 1'b0;
    tick();
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  initial begin
    rst = 1'b1;
    in_valid = 1'b0; in_w_data = '0; in_n_data = '0; acc_done = 1'b0;
    r2_in_valid = 1'b0; r2_in_w_data = '0; r2_in_n_data = '0; r2_acc_done = 1'b0;
    #2;
    check("reset_in_ready", 64'(in_ready), 64'(1));
    check("reset_mm_rst_n", 64'(mm_rst_n), 64'(0));
    check("reset_mm_reset_acc", 64'(mm_reset_acc), 64'(0));
    check("reset_mm_en", 64'(mm_en), 64'(0));
    check("reset_w_dout", 64'(w_dout), 64'(0));
    check("reset_n_dout", 64'(n_dout), 64'(0));
    check("reset_bank_full", 64'(bank_full), 64'(0));
    check("reset_pass_done", 64'(pass_done), 64'(0));
    check("reset_ovf", 64'(ovf_err), 64'(0));
    tick();
    rst = 1'b0;
    tick();
    check("idle_mm_rst_n", 64'(mm_rst_n), 64'(1));

    // Single bank fill and drain
    for (int k = 0; k < 4; k++) wr(1'b0, 0, k, 1'b1);
    check("t1_bank_full", 64'(bank_full), 64'(2'b01));
    check("t1_in_ready", 64'(in_ready), 64'(1));
    tick();
    check("t1_clr_reset_acc", 64'(mm_reset_acc), 64'(1));
    check("t1_clr_mm_rst_n", 64'(mm_rst_n), 64'(0));
    check("t1_clr_mm_en", 64'(mm_en), 64'(0));
    tick();
    check("t1_run_mm_en", 64'(mm_en), 64'(1));
    check("t1_run_mm_rst_n", 64'(mm_rst_n), 64'(1));
    wait_en(1'b0, 1'b0, "t1_wait");
    pq1.push_back(2'b01);
    acc(1'b0);
    check("t1_pass_done", 64'(pass_done), 64'(1));
    tick();
    check("t1_bank_full_clr", 64'(bank_full), 64'(0));
    check("t1_pass_done_low", 64'(pass_done), 64'(0));

    // Both banks full, dropped word, release of bank 0 then bank 1
    do_reset();
    for (int k = 0; k < 8; k++) wr(1'b0, 16, k, 1'b1);
    check("t2_bank_full", 64'(bank_full), 64'(2'b11));
    check("t2_in_ready", 64'(in_ready), 64'(0));
    wr(1'b0, 48, 0, 1'b0);
    check("t2_ovf", 64'(ovf_err), 64'(EXP_OVF));
    wait_en(1'b0, 1'b0, "t4_wait0");
    pq1.push_back(2'b11);
    acc(1'b0);
    check("t4_pass_done", 64'(pass_done), 64'(1));
    check("t4_rel_in_ready", 64'(in_ready), 64'(0));
    tick();
    check("t4_bank_full", 64'(bank_full), 64'(2'b10));
    check("t4_in_ready", 64'(in_ready), 64'(1));
    tick();
    check("t4_clr_reset_acc", 64'(mm_reset_acc), 64'(1));
    check("t4_clr_mm_rst_n", 64'(mm_rst_n), 64'(1));
    wait_en(1'b0, 1'b1, "t4_run1");
    wait_en(1'b0, 1'b0, "t4_wait1");
    pq1.push_back(2'b10);
    acc(1'b0);
    check("t4_pass_done1", 64'(pass_done), 64'(1));
    tick();
    check("t4_bank_full_clr", 64'(bank_full), 64'(0));

    // Reset in the middle of a read pass
    for (int k = 0; k < 4; k++) wr(1'b0, 64, k, k < 2);
    tick();
    tick();
    tick();
    tick();
    check("t5_mm_en_rd2", 64'(mm_en), 64'(1));
    rst = 1'b1;
    #1;
    check("t5_rst_mm_en", 64'(mm_en), 64'(0));
    check("t5_rst_bank_full", 64'(bank_full), 64'(0));
    check("t5_rst_in_ready", 64'(in_ready), 64'(1));
    tick();
    rst = 1'b0;
    tick();
    for (int k = 0; k < 4; k++) wr(1'b0, 80, k, 1'b1);
    check("t5_bank_full", 64'(bank_full), 64'(2'b01));
    wait_en(1'b0, 1'b1, "t5_run");
    wait_en(1'b0, 1'b0, "t5_wait");
    pq1.push_back(2'b01);
    acc(1'b0);
    check("t5_pass_done", 64'(pass_done), 64'(1));
    tick();

    // Spurious acc_done in IDLE and RUN
    acc(1'b0);
    check("t6_idle_pass_done", 64'(pass_done), 64'(0));
    check("t6_idle_bank_full", 64'(bank_full), 64'(0));
    for (int k = 0; k < 4; k++) wr(1'b0, 96, k, 1'b1);
    check("t6_bank_full", 64'(bank_full), 64'(2'b10));
    wait_en(1'b0, 1'b1, "t6_run");
    acc(1'b0);
    check("t6_run_mm_en", 64'(mm_en), 64'(1));
    check("t6_run_pass_done", 64'(pass_done), 64'(0));
    wait_en(1'b0, 1'b0, "t6_wait");
    pq1.push_back(2'b10);
    acc(1'b0);
    check("t6_pass_done", 64'(pass_done), 64'(1));
    tick();
    check("t6_bank_full_clr", 64'(bank_full), 64'(0));

    // REPLAY=2 instance: two identical passes, one release
    for (int k = 0; k < 4; k++) wr(1'b1, 128, k, 1'b1);
    for (int k = 0; k < 4; k++)
      q2.push_back('{w: {16'(128 + k + 1), 16'(128 + k)},
                     n: {16'(32'hB000 + 128 + k), 16'(32'hA000 + 128 + k)}});
    tick();
    check("t3_first_clr_rst_n", 64'(r2_mm_rst_n), 64'(0));
    wait_en(1'b1, 1'b1, "t3_run0");
    wait_en(1'b1, 1'b0, "t3_wait0");
    acc(1'b1);
    check("t3_pass_done0", 64'(r2_pass_done), 64'(0));
    check("t3_replay_clr", 64'(r2_mm_reset_acc), 64'(1));
    check("t3_replay_rst_n", 64'(r2_mm_rst_n), 64'(1));
    wait_en(1'b1, 1'b1, "t3_run1");
    wait_en(1'b1, 1'b0, "t3_wait1");
    pq2.push_back(2'b01);
    acc(1'b1);
    check("t3_pass_done1", 64'(r2_pass_done), 64'(1));
    tick();
    check("t3_bank_full_clr", 64'(r2_bank_full), 64'(0));

    tick();
    tick();
    check("q1_drained", 64'(q1.size()), 64'(0));
    check("q2_drained", 64'(q2.size()), 64'(0));
    check("pq1_drained", 64'(pq1.size()), 64'(0));
    check("pq2_drained", 64'(pq2.size()), 64'(0));
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
